// File: rtl/wb_arbiter.sv
// Write-back arbiter: the pipeline result always wins the register-file port, and
// multi-cycle results wait in a small FIFO. Tracks per-register pending state for decode.
module wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        iss_set,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        q_busy,
    output logic        wb_we,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data
);

    // FIFO_DEPTH is 2 or 4, so pointers wrap naturally at their width
    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];
    logic [31:0]      busy_q, busy_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_reg_q, wb_reg_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic pipe_wr;
    logic enq;
    logic deq;

    assign md_ready      = (count_q < DEPTH_C) && !rst;
    assign q_busy        = busy_q[q_rs] | busy_q[q_rt];
    assign wb_we         = wb_we_q;
    assign wb_write_reg  = wb_reg_q;
    assign wb_write_data = wb_data_q;

    always_comb begin
        pipe_wr     = mem_valid && mem_we && (mem_rd != '0);
        enq         = md_valid && md_ready && (md_rd != '0);
        deq         = !pipe_wr && (count_q != '0);

        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        busy_d      = busy_q;
        wb_we_d     = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;

        if (pipe_wr) begin
            wb_we_d   = 1'b1;
            wb_reg_d  = mem_rd;
            wb_data_d = mem_data;
        end else if (deq) begin
            wb_we_d   = 1'b1;
            wb_reg_d  = fifo_rd_q[rd_ptr_q];
            wb_data_d = fifo_data_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
        end

        if (enq) begin
            fifo_rd_d[wr_ptr_q]   = md_rd;
            fifo_data_d[wr_ptr_q] = md_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Applied after the dequeue clear so a same-edge issue wins
        if (iss_set && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            busy_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            wb_we_q     <= wb_we_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_we, md_valid, iss_set;
    logic [4:0]  mem_rd, md_rd, iss_rd, q_rs, q_rt;
    logic [31:0] mem_data, md_data;
    logic        md_ready, q_busy, wb_we;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [36:0] mq[$];
    bit          mbusy[32];
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .iss_set(iss_set), .iss_rd(iss_rd), .q_rs(q_rs), .q_rt(q_rt), .q_busy(q_busy),
        .wb_we(wb_we), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        e_we = 1'b0; e_reg = '0; e_data = '0;
    endtask

    // One clock edge of the arbiter's rules, applied to the model
    task automatic model_edge();
        logic [36:0] head;
        bit rdy;
        rdy = (mq.size() < DEPTH);
        if (mem_valid && mem_we && mem_rd != 0) begin
            e_we = 1'b1; e_reg = mem_rd; e_data = mem_data;
        end else if (mq.size() != 0) begin
            head = mq.pop_front();
            e_we = 1'b1; e_reg = head[36:32]; e_data = head[31:0];
            mbusy[head[36:32]] = 1'b0;
        end else begin
            e_we = 1'b0;
        end
        if (md_valid && rdy && md_rd != 0) mq.push_back({md_rd, md_data});
        if (iss_set && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    endtask

    task automatic idle();
        mem_valid = 0; mem_we = 0; mem_rd = '0; mem_data = '0;
        md_valid = 0; md_rd = '0; md_data = '0;
        iss_set = 0; iss_rd = '0; q_rs = '0; q_rt = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_reset();
        q_rs = 5'd5; q_rt = 5'd9;
        #3;
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb_we); end
        checks++; if (wb_write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg: got %0d want 0", wb_write_reg); end
        checks++; if (wb_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", wb_write_data); end
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", md_ready); end
        checks++; if (q_busy !== 1'b0) begin errors++; $display("FAIL reset_qbusy: got %b want 0", q_busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", md_ready); end
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_idle_we: got %b want 0", wb_we); end
    endtask

    task automatic test_pipe_write();
        idle();
        mem_valid = 1; mem_we = 1; mem_rd = 5'd5; mem_data = 32'h1234;
        tick();
        checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL pipe_we: got %b want 1", wb_we); end
        checks++; if (wb_write_reg !== 5'd5) begin errors++; $display("FAIL pipe_reg: got %0d want 5", wb_write_reg); end
        checks++; if (wb_write_data !== 32'h1234) begin errors++; $display("FAIL pipe_data: got %h want 1234", wb_write_data); end
        idle();
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL pipe_idle_we: got %b want 0", wb_we); end
        checks++; if (wb_write_reg !== 5'd5 || wb_write_data !== 32'h1234) begin
            errors++; $display("FAIL pipe_hold: got %0d/%h want 5/1234", wb_write_reg, wb_write_data);
        end
    endtask

    task automatic test_busy_track();
        idle();
        iss_set = 1; iss_rd = 5'd7;
        tick();
        idle(); q_rs = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (q_busy !== 1'b1) begin errors++; $display("FAIL busy_pending: got %b want 1 (cycle %0d)", q_busy, c); end
            tick();
        end
        md_valid = 1; md_rd = 5'd7; md_data = 32'hCAFE;
        #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL busy_md_ready: got %b want 1", md_ready); end
        tick();
        idle(); q_rs = 5'd7;
        #1;
        checks++; if (wb_we !== 1'b0 || q_busy !== 1'b1) begin
            errors++; $display("FAIL busy_accept_edge: got we=%b qb=%b want we=0 qb=1", wb_we, q_busy);
        end
        tick();
        checks++; if (wb_we !== 1'b1 || wb_write_reg !== 5'd7 || wb_write_data !== 32'hCAFE) begin
            errors++; $display("FAIL busy_wb: got %b/%0d/%h want 1/7/cafe", wb_we, wb_write_reg, wb_write_data);
        end
        checks++; if (q_busy !== 1'b0) begin errors++; $display("FAIL busy_cleared: got %b want 0", q_busy); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] prd;
        logic [31:0] pdata;
        int idx;
        bit ex_rdy;
        idle();
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            prd = 5'($urandom_range(10, 31)); pdata = $urandom;
            mem_valid = 1; mem_we = 1; mem_rd = prd; mem_data = pdata;
            md_valid = (idx < 3); md_rd = 5'(idx + 1); md_data = 32'hA0 + 32'(idx + 1);
            #1;
            ex_rdy = (idx < 2);
            checks++; if (md_ready !== ex_rdy) begin errors++; $display("FAIL b2b_ready: got %b want %b (cycle %0d)", md_ready, ex_rdy, c); end
            if (md_valid && ex_rdy) idx++;
            tick();
            checks++; if (wb_we !== 1'b1 || wb_write_reg !== prd || wb_write_data !== pdata) begin
                errors++; $display("FAIL b2b_pipe: got %b/%0d/%h want 1/%0d/%h", wb_we, wb_write_reg, wb_write_data, prd, pdata);
            end
        end
        mem_valid = 0; mem_we = 0;
        for (int k = 0; k < 4; k++) begin
            md_valid = (idx < 3); md_rd = 5'(idx + 1); md_data = 32'hA0 + 32'(idx + 1);
            #1;
            ex_rdy = (mq.size() < DEPTH);
            checks++; if (md_ready !== ex_rdy) begin errors++; $display("FAIL b2b_drain_ready: got %b want %b (k %0d)", md_ready, ex_rdy, k); end
            if (md_valid && ex_rdy) idx++;
            tick();
            if (k < 3) begin
                checks++; if (wb_we !== 1'b1 || wb_write_reg !== 5'(k + 1) || wb_write_data !== 32'hA0 + 32'(k + 1)) begin
                    errors++; $display("FAIL b2b_order: got %b/%0d/%h want 1/%0d/%h", wb_we, wb_write_reg, wb_write_data, k + 1, 32'hA0 + 32'(k + 1));
                end
            end else begin
                checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", wb_we); end
            end
        end
        idle();
    endtask

    task automatic test_zero_rd();
        idle();
        for (int c = 0; c < 4; c++) begin
            mem_valid = 1; mem_we = 1; mem_rd = 5'd0; mem_data = 32'hFFFF;
            md_valid = 1; md_rd = 5'd0; md_data = 32'hBEEF;
            #1;
            checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1 (cycle %0d)", md_ready, c); end
            tick();
            checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0 (cycle %0d)", wb_we, c); end
        end
        idle();
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL zero_fifo_empty: got %b want 0", wb_we); end
    endtask

    task automatic test_set_clear();
        idle();
        iss_set = 1; iss_rd = 5'd9;
        tick();
        idle(); md_valid = 1; md_rd = 5'd9; md_data = 32'h99;
        tick();
        idle(); iss_set = 1; iss_rd = 5'd9; q_rs = 5'd9;
        #1;
        checks++; if (q_busy !== 1'b1) begin errors++; $display("FAIL setclr_before: got %b want 1", q_busy); end
        tick();
        idle(); q_rt = 5'd9;
        #1;
        checks++; if (wb_we !== 1'b1 || wb_write_reg !== 5'd9 || wb_write_data !== 32'h99) begin
            errors++; $display("FAIL setclr_wb: got %b/%0d/%h want 1/9/99", wb_we, wb_write_reg, wb_write_data);
        end
        checks++; if (q_busy !== 1'b1) begin errors++; $display("FAIL setclr_set_wins: got %b want 1", q_busy); end
        md_valid = 1; md_rd = 5'd9; md_data = 32'h999;
        tick();
        idle(); q_rt = 5'd9;
        tick();
        checks++; if (q_busy !== 1'b0 || wb_write_reg !== 5'd9) begin
            errors++; $display("FAIL setclr_final: got qb=%b reg=%0d want qb=0 reg=9", q_busy, wb_write_reg);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        iss_set = 1; iss_rd = 5'd4;
        mem_valid = 1; mem_we = 1; mem_rd = 5'd20; mem_data = 32'h5555;
        md_valid = 1; md_rd = 5'd4; md_data = 32'h44;
        tick();
        iss_set = 0; mem_rd = 5'd21; md_rd = 5'd11; md_data = 32'h11;
        tick();
        md_valid = 0; q_rs = 5'd4;
        #1;
        checks++; if (md_ready !== 1'b0 || q_busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got ready=%b qb=%b want 0/1", md_ready, q_busy);
        end
        #3;
        rst = 1'b1;
        idle(); q_rs = 5'd4;
        model_reset();
        #1;
        checks++; if (wb_we !== 1'b0 || wb_write_reg !== 5'd0 || wb_write_data !== 32'd0) begin
            errors++; $display("FAIL rstmid_wb: got %b/%0d/%h want 0/0/0", wb_we, wb_write_reg, wb_write_data);
        end
        checks++; if (md_ready !== 1'b0 || q_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: got ready=%b qb=%b want 0/0", md_ready, q_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (md_ready !== 1'b1 || q_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_release: got ready=%b qb=%b want 1/0", md_ready, q_busy);
        end
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got %b want 0", wb_we); end
    endtask

    task automatic test_random();
        bit ex_rdy, ex_qb;
        for (int c = 0; c < 400; c++) begin
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_we    = ($urandom_range(0, 3) != 0);
            mem_rd    = 5'($urandom_range(0, 31));
            mem_data  = $urandom;
            md_valid  = ($urandom_range(0, 1) == 0);
            md_rd     = 5'($urandom_range(0, 7));
            md_data   = $urandom;
            iss_set   = ($urandom_range(0, 2) == 0);
            iss_rd    = 5'($urandom_range(0, 7));
            q_rs      = 5'($urandom_range(0, 8));
            q_rt      = 5'($urandom_range(0, 8));
            #1;
            ex_rdy = (mq.size() < DEPTH);
            ex_qb  = mbusy[q_rs] | mbusy[q_rt];
            checks++; if (md_ready !== ex_rdy) begin errors++; $display("FAIL rand_ready: got %b want %b (cycle %0d)", md_ready, ex_rdy, c); end
            checks++; if (q_busy !== ex_qb) begin errors++; $display("FAIL rand_qbusy: got %b want %b (cycle %0d)", q_busy, ex_qb, c); end
            tick();
            checks++; if (wb_we !== e_we || wb_write_reg !== e_reg || wb_write_data !== e_data) begin
                errors++; $display("FAIL rand_wb: got %b/%0d/%h want %b/%0d/%h (cycle %0d)",
                                   wb_we, wb_write_reg, wb_write_data, e_we, e_reg, e_data, c);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_busy_track();
        test_back_to_back();
        test_zero_rd();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered multi-cycle results; legal values 2 or 4.
REQ-002 SHALL have clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have mem_valid  input  1  pipeline (MEM stage) result present this cycle.
REQ-005 SHALL have mem_we  input  1  pipeline result writes a register.
REQ-006 SHALL have mem_rd  input  5  pipeline destination register.
REQ-007 SHALL have mem_data  input  32  pipeline result data.
REQ-008 SHALL have md_valid  input  1  multi-cycle (mul/div) result offered.
REQ-009 SHALL have md_rd  input  5  multi-cycle destination register.
REQ-010 SHALL have md_data  input  32  multi-cycle result data.
REQ-011 SHALL have md_ready  output  1  multi-cycle result accepted when md_valid && md_ready.
REQ-012 SHALL have iss_set  input  1  long-latency op issued; mark iss_rd pending.
REQ-013 SHALL have iss_rd  input  5  destination of issued long-latency op.
REQ-014 SHALL have q_rs  input  5  decode source register 1 query.
REQ-015 SHALL have q_rt  input  5  decode source register 2 query.
REQ-016 SHALL have q_busy  output  1  either queried register pending; decode stalls.
REQ-017 SHALL have wb_we  output  1  register-file write enable, registered.
REQ-018 SHALL have wb_write_reg  output  5  register-file write address, registered.
REQ-019 SHALL have wb_write_data  output  32  register-file write data, registered.

Function
REQ-020 SHALL define a pipeline write as mem_valid && mem_we && mem_rd != 0; a pipeline write SHALL load wb_we=1, wb_write_reg=mem_rd, wb_write_data=mem_data on the next edge (latency 1).
REQ-021 SHALL give pipeline writes absolute priority; the pipeline is never back-pressured.
REQ-022 SHALL enqueue {md_rd, md_data} into a FIFO_DEPTH-entry circular FIFO on md_valid && md_ready && md_rd != 0; an accepted md_rd == 0 is discarded.
REQ-023 SHALL drive md_ready = (count < FIFO_DEPTH) && !rst, from registered count only; no same-cycle pass-through at full.
REQ-024 SHALL, in a cycle with no pipeline write and count != 0, dequeue the FIFO head to wb_* on the edge (wb_we=1); with neither source, wb_we=0 and wb_write_reg/wb_write_data hold.
REQ-025 SHALL allow simultaneous enqueue and dequeue, leaving count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL make an accepted md result appear on wb_* no earlier than the second edge after acceptance.
REQ-027 SHALL keep a busy bit per register 1..31; busy[0] is constant 0.
REQ-028 SHALL set busy[iss_rd] on an edge with iss_set && iss_rd != 0.
REQ-029 SHALL clear busy[r] on the edge that dequeues an FIFO entry with destination r.
REQ-030 SHALL give set priority over clear when both target the same register on the same edge.
REQ-031 SHALL drive q_busy = busy[q_rs] | busy[q_rt] combinationally; during the cycle wb_we is visible for r, busy[r] is already clear (register-file forwarding covers the read).
REQ-032 SHALL perform pipeline writes to a busy register without altering its busy bit.

Reset
REQ-033 SHALL, while rst=1, asynchronously force wb_we=0, wb_write_reg=0, wb_write_data=0, count=0, both pointers=0, all busy bits=0, md_ready=0, q_busy=0.
REQ-034 SHALL discard FIFO contents and pending busy bits on reset mid-operation; first edge after rst deasserts behaves as from empty.

Verification
REQ-035 SHALL cover: mem_valid=1, mem_we=1, mem_rd=5, mem_data=0x1234 -> next cycle wb_we=1, wb_write_reg=5, wb_write_data=0x1234.
REQ-036 SHALL cover: iss_set rd=7; later md_valid rd=7 data=0xCAFE with idle pipeline -> q_busy=1 for q_rs=7 until the cycle wb_we=1, reg=7, data=0xCAFE, where q_busy=0.
REQ-037 SHALL cover: three md results rd=1,2,3 back-to-back while pipeline writes every cycle -> md_ready drops after two accepts; when pipeline idles, writes 1,2,3 in order, one per cycle.
REQ-038 SHALL cover: mem write rd=0 and md result rd=0 -> wb_we stays 0, FIFO count stays 0.
REQ-039 SHALL cover: busy[9] clear-by-dequeue and iss_set rd=9 same edge -> busy[9]=1 afterwards.
REQ-040 SHALL cover: rst pulsed mid-cycle with count=2, busy[4]=1 -> all outputs 0 immediately, md_ready=1 and q_busy=0 after release.
